// File: rtl/bcd_pkg.sv
// Shared state encoding, digit constants and helpers for the iterative binary-to-BCD scheduler.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int         DIGIT_W     = 4;
  localparam logic [3:0] ADD3_THRESH = 4'd5;

  // Double-dabble correction: a digit of 5 or more overflows past 9 once doubled,
  // so pre-add 3 to make the following shift carry into the next digit.
  function automatic logic [DIGIT_W-1:0] add3_fix(input logic [DIGIT_W-1:0] d);
    return (d >= ADD3_THRESH) ? d + 4'd3 : d;
  endfunction

  // Elaboration helper used to check that DIGITS can hold the largest operand.
  function automatic longint pow10(input int n);
    longint p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

endpackage

// File: rtl/bcd_shift_core.sv
// Sequential shift/add-3 datapath: converts one WIDTH-bit operand into DIGITS BCD digits.
// Latency: WIDTH cycles of shifting after i_start, then o_done pulses for one cycle.
// Backpressure: none; a new i_start reloads the register and restarts the conversion.
module bcd_shift_core
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      i_start,
  input  logic [WIDTH-1:0]          i_operand,
  output logic                      o_last,
  output logic                      o_done,
  output logic [DIGITS*DIGIT_W-1:0] o_result
);

  localparam int BCD_W = DIGITS * DIGIT_W;
  localparam int SR_W  = BCD_W + WIDTH;
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [SR_W-1:0]  r_sr;
  logic [SR_W-1:0]  w_adj;
  logic [CNT_W-1:0] r_cnt;
  logic             r_run;
  logic             r_done;

  // Apply the add-3 correction to every digit nibble; the binary part passes through.
  always_comb begin
    w_adj = r_sr;
    for (int d = 0; d < DIGITS; d++) begin
      w_adj[WIDTH + d*DIGIT_W +: DIGIT_W] = add3_fix(r_sr[WIDTH + d*DIGIT_W +: DIGIT_W]);
    end
  end

  // Load on start, then one correct-and-shift per cycle until WIDTH iterations are done.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sr   <= '0;
      r_cnt  <= '0;
      r_run  <= 1'b0;
      r_done <= 1'b0;
    end else if (i_start) begin
      r_sr   <= {{BCD_W{1'b0}}, i_operand};
      r_cnt  <= '0;
      r_run  <= 1'b1;
      r_done <= 1'b0;
    end else if (r_run) begin
      r_sr  <= w_adj << 1;
      r_cnt <= r_cnt + CNT_W'(1);
      if (r_cnt == CNT_W'(WIDTH - 1)) begin
        r_run  <= 1'b0;
        r_done <= 1'b1;
      end
    end else begin
      r_done <= 1'b0;
    end
  end

  assign o_last   = r_run && (r_cnt == CNT_W'(WIDTH - 1));
  assign o_done   = r_done;
  assign o_result = r_sr[SR_W-1 -: BCD_W];

endmodule

// File: rtl/bcd_conv_sched.sv
// Round-robin scheduler sharing one iterative binary-to-BCD core among NREQ display channels.
// Latency: req sampled at edge E0 -> bcd written and ack pulsed after edge E0+WIDTH+1.
// Backpressure: requesters hold req until ack; one conversion per WIDTH+2 cycles.
module bcd_conv_sched
  import bcd_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ*WIDTH-1:0]      binario,
  output logic [NREQ-1:0]            ack,
  output logic                       busy,
  output logic [NREQ*DIGITS*4-1:0]   bcd
);

  localparam int BCD_W = DIGITS * DIGIT_W;
  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 1 || NREQ > 4) begin : g_bad_nreq
    $error("bcd_conv_sched: NREQ must be in 1..4");
  end
  if (WIDTH < 1 || WIDTH > 9) begin : g_bad_width
    $error("bcd_conv_sched: WIDTH must be in 1..9");
  end
  if (pow10(DIGITS) <= ((longint'(1) << WIDTH) - 1)) begin : g_bad_digits
    $error("bcd_conv_sched: DIGITS too small for the largest WIDTH-bit operand");
  end

  state_t              r_state;
  state_t              w_state_nxt;
  logic [PTR_W-1:0]    r_ptr;
  logic [PTR_W-1:0]    r_grant;
  logic [PTR_W-1:0]    w_gidx;
  logic                w_gvld;
  logic                w_start;
  logic                w_write;
  logic [NREQ-1:0]     w_elig;
  logic [NREQ-1:0]     r_ack;
  logic                r_busy;
  logic [NREQ*BCD_W-1:0] r_bcd;
  logic [WIDTH-1:0]    w_operand;
  logic                w_last;
  logic                w_done;
  logic [BCD_W-1:0]    w_result;

  // A channel whose ack is high this cycle already has its result; never re-grant it now.
  assign w_elig = req & ~r_ack;

  // Round-robin pick: first eligible channel at or after the pointer, wrapping.
  always_comb begin
    w_gvld = 1'b0;
    w_gidx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!w_gvld && w_elig[(int'(r_ptr) + i) % NREQ]) begin
        w_gvld = 1'b1;
        w_gidx = PTR_W'((int'(r_ptr) + i) % NREQ);
      end
    end
  end

  // Select the operand of the channel being granted; it is captured only at grant.
  always_comb begin
    w_operand = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gidx == PTR_W'(i)) w_operand = binario[i*WIDTH +: WIDTH];
    end
  end

  // FSM next-state: grant in IDLE, iterate in SHIFT, write back in DONE.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_write     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_gvld) begin
          w_start     = 1'b1;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        if (w_done) begin
          w_write     = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM state register; busy is registered from the next state so it has no input path.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != IDLE);
    end
  end

  // Remember the granted channel and advance the pointer past it once it is served.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_grant <= '0;
      r_ptr   <= '0;
    end else begin
      if (w_start) r_grant <= w_gidx;
      if (w_write) r_ptr <= (r_grant == PTR_W'(NREQ - 1)) ? '0 : r_grant + PTR_W'(1);
    end
  end

  // Write the finished digits into the granted channel only, and pulse its ack.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ack <= '0;
      r_bcd <= '0;
    end else begin
      for (int c = 0; c < NREQ; c++) begin
        r_ack[c] <= w_write && (r_grant == PTR_W'(c));
        if (w_write && (r_grant == PTR_W'(c))) r_bcd[c*BCD_W +: BCD_W] <= w_result;
      end
    end
  end

  bcd_shift_core #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) u_core (
    .clock     (clock),
    .reset_n   (reset_n),
    .i_start   (w_start),
    .i_operand (w_operand),
    .o_last    (w_last),
    .o_done    (w_done),
    .o_result  (w_result)
  );

  assign ack  = r_ack;
  assign busy = r_busy;
  assign bcd  = r_bcd;

endmodule

// File: tb/tb_bcd_conv_sched.sv
// Directed bench for bcd_conv_sched: vector table, arbitration, abort and full-range sweep.
// Latency: checks ack/bcd exactly WIDTH+1 edges after the sampling edge.
// Backpressure: requests held until ack, dropped on the ack cycle.
module tb_bcd_conv_sched;

  localparam int NREQ   = 2;
  localparam int WIDTH  = 8;
  localparam int DIGITS = 3;
  localparam int BCD_W  = DIGITS * 4;

  logic                    clock = 1'b0;
  logic                    reset_n;
  logic [NREQ-1:0]         req;
  logic [NREQ*WIDTH-1:0]   binario;
  logic [NREQ-1:0]         ack;
  logic                    busy;
  logic [NREQ*BCD_W-1:0]   bcd;

  int checks   = 0;
  int failures = 0;
  logic [NREQ*BCD_W-1:0] exp_bcd;

  typedef struct {
    int               ch;
    logic [WIDTH-1:0] val;
    logic [BCD_W-1:0] exp;
  } vec_t;

  vec_t vecs[12];

  bcd_conv_sched #(
    .NREQ   (NREQ),
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .req     (req),
    .binario (binario),
    .ack     (ack),
    .busy    (busy),
    .bcd     (bcd)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [BCD_W-1:0] ref_bcd(input int v);
    logic [BCD_W-1:0] r;
    r[11:8] = 4'(v / 100);
    r[7:4]  = 4'((v / 10) % 10);
    r[3:0]  = 4'(v % 10);
    return r;
  endfunction

  // Caller sits at the negedge after the sampling edge; n counts further edges until ack.
  task automatic wait_ack(input int ch, output int n);
    n = 0;
    while (!ack[ch] && n < 40) begin
      @(negedge clock);
      n++;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req     = '0;
    binario = '0;
    repeat (2) @(negedge clock);
    check("reset state", {ack, busy, bcd}, 64'd0);
    reset_n = 1'b1;
    exp_bcd = '0;
  endtask

  task automatic convert(input int ch, input logic [WIDTH-1:0] val,
                         input logic [BCD_W-1:0] exp, input string tag);
    int n;
    binario[ch*WIDTH +: WIDTH] = val;
    req[ch] = 1'b1;
    @(negedge clock);
    check({tag, " busy"}, busy, 1);
    wait_ack(ch, n);
    req[ch] = 1'b0;
    exp_bcd[ch*BCD_W +: BCD_W] = exp;
    check({tag, " latency"}, n, WIDTH + 1);
    check({tag, " ack"}, ack, 1 << ch);
    check({tag, " bcd"}, bcd, exp_bcd);
    @(negedge clock);
    check({tag, " ack one cycle"}, ack, 0);
    check({tag, " idle after"}, busy, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int n_acks;
    int n_double;

    vecs[0]  = '{0, 8'd255, 12'h255};
    vecs[1]  = '{1, 8'd0,   12'h000};
    vecs[2]  = '{1, 8'd99,  12'h099};
    vecs[3]  = '{0, 8'd9,   12'h009};
    vecs[4]  = '{0, 8'd10,  12'h010};
    vecs[5]  = '{0, 8'd100, 12'h100};
    vecs[6]  = '{0, 8'd199, 12'h199};
    vecs[7]  = '{1, 8'd128, 12'h128};
    vecs[8]  = '{1, 8'd77,  12'h077};
    vecs[9]  = '{0, 8'd1,   12'h001};
    vecs[10] = '{1, 8'd150, 12'h150};
    vecs[11] = '{1, 8'd200, 12'h200};

    reset_n = 1'b0;
    req     = '0;
    binario = '0;
    exp_bcd = '0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;

    // Idle with no requests for 20 cycles.
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      check("idle outputs", {ack, busy, bcd}, 64'd0);
    end

    // Maximum operand on channel 0; channel 1 must remain zero.
    convert(0, 8'd255, 12'h255, "max ch0");

    // Both channels held: ch0, ch1, ch0 at edges 9, 19, 29, never together.
    do_reset();
    binario = {8'd99, 8'd0};
    req     = 2'b11;
    n_acks   = 0;
    n_double = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (ack != 2'b00) n_acks++;
      if (ack == 2'b11) n_double++;
      if (i == 9) begin
        check("rr first ack", ack, 2'b01);
        check("rr ch0 bcd", bcd, {12'h000, 12'h000});
      end
      if (i == 19) begin
        check("rr second ack", ack, 2'b10);
        check("rr ch1 bcd", bcd, {12'h099, 12'h000});
      end
      if (i == 29) check("rr third ack", ack, 2'b01);
    end
    req = 2'b00;
    check("rr ack count", n_acks, 3);
    check("rr double ack", n_double, 0);
    repeat (2) @(negedge clock);
    check("rr idle after", busy, 0);
    exp_bcd = {12'h099, 12'h000};

    // Operand captured at grant; later change and dropped req are ignored.
    binario[15:8] = 8'd128;
    req = 2'b10;
    @(negedge clock);
    n = 0;
    while (!ack[1] && n < 40) begin
      if (n == 2) binario[15:8] = 8'd7;
      if (n == 4) req[1] = 1'b0;
      @(negedge clock);
      n++;
    end
    exp_bcd[23:12] = 12'h128;
    check("capture latency", n, WIDTH + 1);
    check("capture ack", ack, 2'b10);
    check("capture bcd", bcd, exp_bcd);
    @(negedge clock);
    check("capture ack one cycle", ack, 0);

    // Reset mid-conversion aborts asynchronously; a fresh conversion follows release.
    binario[7:0] = 8'd77;
    req = 2'b01;
    repeat (4) @(negedge clock);
    check("abort busy before", busy, 1);
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1 check("abort async", {ack, busy, bcd}, 64'd0);
    repeat (2) @(negedge clock);
    check("abort held", {ack, busy, bcd}, 64'd0);
    reset_n = 1'b1;
    exp_bcd = '0;
    @(negedge clock);
    check("restart busy", busy, 1);
    wait_ack(0, n);
    req = 2'b00;
    check("restart latency", n, WIDTH + 1);
    check("restart ack", ack, 2'b01);
    check("restart bcd", bcd, {12'h000, 12'h077});
    exp_bcd[11:0] = 12'h077;
    @(negedge clock);

    // Directed vector table.
    for (int i = 0; i < 12; i++) begin
      convert(vecs[i].ch, vecs[i].val, vecs[i].exp, $sformatf("vec %0d", i));
    end

    // Full operand range, alternating channels, against the arithmetic model.
    for (int v = 0; v < 256; v++) begin
      convert(v % 2, 8'(v), ref_bcd(v), $sformatf("sweep %0d", v));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_conv_sched.md
Name: bcd_conv_sched

Overview:
Shared, iterative binary-to-BCD conversion engine with round-robin arbitration between NREQ requesters, e.g. the PC, register and output-port 7-segment display paths. It replaces a per-display combinational converter with one sequential shift/add-3 datapath. Each requester holds a request until acknowledged. The block writes that requester's hundreds/tens/units digits into a per-channel holding register, which drives its display decoder.

Parameters:
NREQ, 2, number of requesting channels (1..4)
WIDTH, 8, binary operand width in bits (1..9)
DIGITS, 3, BCD digits produced per channel; must satisfy 10^DIGITS > 2^WIDTH-1, checked at elaboration

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
req  input  NREQ  per-channel conversion request, level, held until ack
binario  input  NREQ*WIDTH  per-channel operand, channel i at [i*WIDTH +: WIDTH]
ack  output  NREQ  one-cycle pulse: channel's bcd register updated this cycle
busy  output  1  high while a conversion is in progress (states SHIFT, DONE)
bcd  output  NREQ*DIGITS*4  per-channel result, channel i at [i*DIGITS*4 +: DIGITS*4], units in the low nibble

Behaviour:
- Clocking and reset: one clock, `clock`; reset is asynchronous, active-low (`reset_n`).
- Reset values:
  - state=IDLE, ack=0, busy=0, all bcd=0.
  - Round-robin pointer set so channel 0 has highest priority; shift register and counter 0.
- FSM IDLE -> SHIFT -> DONE -> IDLE.
- IDLE:
  - Eligible set = req & ~ack. A channel acked this cycle is never re-granted in the same cycle.
  - If the set is non-empty, grant the first eligible channel at or after the pointer (wrapping), then:
    - Load the shift register: upper DIGITS*4 bits = 0, low WIDTH bits = that channel's operand.
    - Counter = 0; go to SHIFT.
- SHIFT, one iteration per cycle:
  - Every digit nibble >= 5 gets +3 (mod 16); then the whole register shifts left by 1.
  - Counter increments. After the WIDTH-th iteration, go to DONE.
- DONE:
  - bcd[grant] <= upper DIGITS*4 bits; ack[grant] = 1 for exactly this one cycle.
  - Pointer <= grant+1 mod NREQ; go to IDLE. Other channels' bcd registers are untouched.
- Latency: req sampled at edge E0 gives bcd update and ack high after edge E0+WIDTH+1, i.e. E9 for WIDTH=8. Throughput is one conversion per WIDTH+2 cycles.
- The operand is captured at grant. Later changes to binario are ignored until the next grant.
- req dropped mid-conversion: the conversion still completes and is written and acked.
- Simultaneous requests are served in round-robin order, so a continuously held req is served every NREQ conversions at worst.
- Outputs ack, busy and bcd are registered; no combinational path from inputs to outputs.
- Reset mid-conversion aborts immediately: no ack; bcd returns to 0.
- Operand value 0 yields all-zero digits. Maximum operand yields the correct digits with no overflow, per the DIGITS constraint.

Decomposition:
- Package bcd_pkg holds:
  - the state encoding (IDLE, SHIFT, DONE);
  - DIGIT_W=4 and ADD3_THRESH=5;
  - a function for the per-nibble add-3 correction.
- One sub-module, bcd_shift_core, holds the shift register, iteration counter, start/done and the result bus.
- The top level bcd_conv_sched holds arbitration, the pointer, the FSM glue, the per-channel bcd registers and ack generation.

Test Plan:
1. Reset then idle, no req -> bcd=0 on all channels, ack=0, busy=0 for 20 cycles. Assert reset_n low mid-run -> same values immediately, asynchronously.
2. req[0]=1, binario ch0=8'd255 at E0 -> busy from E0. Ack[0] high for exactly one cycle after E9; bcd ch0 = 2,5,5; ch1 stays 0.
3. req=2'b11 at E0, ch0=8'd0, ch1=8'd99, both held -> ch0 acked after E9 (0,0,0), ch1 acked after E19 (0,9,9), ch0 again after E29. Never two acks at once.
4. ch1 binario=8'd128 granted at E0, changed to 8'd7 at E3, req dropped at E5 -> ack[1] after E9; bcd ch1 = 1,2,8.
5. Reset asserted at E4 of a conversion on ch0 (operand 8'd77) -> no ack, busy=0, bcd=0. After release with req held, fresh conversion acked WIDTH+1 edges after the first post-reset sampling edge; result 0,7,7.
6. Sweep ch0 with 8'd9, 8'd10, 8'd100, 8'd199 -> digits 0,0,9 / 0,1,0 / 1,0,0 / 1,9,9. Compare against a reference model for all 256 values.
